// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Consumer end of a dual-lane retirement interface. Captures up to two retired
//   instructions per cycle in program order (lane A before lane B) into a record FIFO,
//   and drains it as a single-record valid/ready trace stream. Every accepted record
//   is tagged with a sequence number. Records lost to a full FIFO set a sticky overflow
//   flag and bump a saturating drop counter.
//
//   Ports
//     clk, reset (async, active-low), trace_clear (sync clear)
//     retire_*_a / retire_*_b : retirement lanes A and B
//     trace_valid / trace_ready : head-record handshake
//     trace_lane, trace_seq, trace_pc, trace_inst, trace_reg_addr, trace_reg_data,
//     trace_mem_addr, trace_mem_data, trace_mem_wrt : head record fields
//     overflow, drop_count : loss reporting
//
//   Build option
//     RETIRE_TRACE_FILTER_EN : drop retirements that write no register and store nothing
//     (not pushed, no sequence number, not counted as a drop).

module retire_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEQ_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trace_clear,
  input  logic             retire_valid_a,
  input  logic [31:0]      retire_pc_a,
  input  logic [31:0]      retire_inst_a,
  input  logic [4:0]       retire_reg_addr_a,
  input  logic [31:0]      retire_reg_data_a,
  input  logic [31:0]      retire_mem_addr_a,
  input  logic [31:0]      retire_mem_data_a,
  input  logic             retire_mem_wrt_a,
  input  logic             retire_valid_b,
  input  logic [31:0]      retire_pc_b,
  input  logic [31:0]      retire_inst_b,
  input  logic [4:0]       retire_reg_addr_b,
  input  logic [31:0]      retire_reg_data_b,
  input  logic [31:0]      retire_mem_addr_b,
  input  logic [31:0]      retire_mem_data_b,
  input  logic             retire_mem_wrt_b,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic             trace_lane,
  output logic [SEQ_W-1:0] trace_seq,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_inst,
  output logic [4:0]       trace_reg_addr,
  output logic [31:0]      trace_reg_data,
  output logic [31:0]      trace_mem_addr,
  output logic [31:0]      trace_mem_data,
  output logic             trace_mem_wrt,
  output logic             overflow,
  output logic [SEQ_W-1:0] drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef struct packed {
    logic             lane;
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [4:0]       reg_addr;
    logic [31:0]      reg_data;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic             mem_wrt;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            head_q, head_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nx;
  logic [OccW-1:0] occ_q, occ_d, free, occ_rem;
  logic [SEQ_W-1:0] seq_q, seq_d, drop_q, drop_d;
  logic [SEQ_W:0]  drop_sum;
  logic            ovf_q, ovf_d;
  logic            keep_a, keep_b, pop, we0, we1;
  logic [1:0]      n_cand, n_acc, n_drop;
  rec_t            rec_a, rec_b, rec0, rec1;

`ifdef RETIRE_TRACE_FILTER_EN
  assign keep_a = retire_valid_a && ((retire_reg_addr_a != 5'd0) || retire_mem_wrt_a);
  assign keep_b = retire_valid_b && ((retire_reg_addr_b != 5'd0) || retire_mem_wrt_b);
`else
  assign keep_a = retire_valid_a;
  assign keep_b = retire_valid_b;
`endif

  always_comb begin
    rec_a = '{lane: 1'b0, seq: seq_q, pc: retire_pc_a, inst: retire_inst_a,
              reg_addr: retire_reg_addr_a, reg_data: retire_reg_data_a,
              mem_addr: retire_mem_addr_a, mem_data: retire_mem_data_a,
              mem_wrt: retire_mem_wrt_a};
    // B follows A's sequence number only when A is actually a candidate.
    rec_b = '{lane: 1'b1, seq: keep_a ? seq_q + SEQ_W'(1) : seq_q, pc: retire_pc_b,
              inst: retire_inst_b, reg_addr: retire_reg_addr_b, reg_data: retire_reg_data_b,
              mem_addr: retire_mem_addr_b, mem_data: retire_mem_data_b,
              mem_wrt: retire_mem_wrt_b};
    rec0 = keep_a ? rec_a : rec_b;
    rec1 = rec_b;
  end

  always_comb begin
    // Free space comes from the registered occupancy; a same-cycle pop does not help.
    free   = OccW'(DEPTH) - occ_q;
    n_cand = {1'b0, keep_a} + {1'b0, keep_b};
    if (free >= {{(PtrW - 1){1'b0}}, n_cand}) begin
      n_acc = n_cand;
    end else begin
      n_acc = free[1:0];
    end
    n_drop   = n_cand - n_acc;
    pop      = (occ_q != '0) && trace_ready;
    we0      = !trace_clear && (n_acc != 2'd0);
    we1      = !trace_clear && (n_acc == 2'd2);
    wr_ptr_nx = wr_ptr_q + PtrW'(1);

    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(n_acc);
    occ_rem  = occ_q - OccW'(pop);
    occ_d    = occ_rem + OccW'(n_acc);
    seq_d    = seq_q + SEQ_W'(n_acc);
    drop_sum = {1'b0, drop_q} + (SEQ_W + 1)'(n_drop);
    drop_d   = drop_sum[SEQ_W] ? '1 : drop_sum[SEQ_W-1:0];
    ovf_d    = ovf_q | (n_drop != 2'd0);

    // Output register tracks the post-cycle head; holds its last value once empty.
    head_d = head_q;
    if (occ_rem != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (n_acc != 2'd0) begin
      head_d = rec0;
    end

    if (trace_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      seq_d    = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
      head_d   = head_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset: only occupied slots are ever read into the head register.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q] <= rec0;
    if (we1) mem_q[wr_ptr_nx] <= rec1;
  end

  assign trace_valid    = (occ_q != '0);
  assign trace_lane     = head_q.lane;
  assign trace_seq      = head_q.seq;
  assign trace_pc       = head_q.pc;
  assign trace_inst     = head_q.inst;
  assign trace_reg_addr = head_q.reg_addr;
  assign trace_reg_data = head_q.reg_data;
  assign trace_mem_addr = head_q.mem_addr;
  assign trace_mem_data = head_q.mem_data;
  assign trace_mem_wrt  = head_q.mem_wrt;
  assign overflow       = ovf_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized and directed bench for retire_trace_buffer against a queue-based reference model.
module tb_retire_trace_buffer;

  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic        lane;
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wrt;
  } rec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] ma;
    logic [31:0] md;
    logic        mw;
  } ret_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic ready = 1'b0;
  ret_t in_a = '0;
  ret_t in_b = '0;

  logic        trace_valid, trace_lane, trace_mem_wrt, overflow;
  logic [31:0] trace_seq, trace_pc, trace_inst, trace_reg_data, trace_mem_addr, trace_mem_data;
  logic [31:0] drop_count;
  logic [4:0]  trace_reg_addr;

  int n_checks = 0;
  int n_bad = 0;

  // Reference model state
  rec_t        mq[$];
  rec_t        m_last = '0;
  logic [31:0] m_seq = '0;
  logic [31:0] m_drop = '0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .trace_clear       (clear),
    .retire_valid_a    (in_a.valid),
    .retire_pc_a       (in_a.pc),
    .retire_inst_a     (in_a.inst),
    .retire_reg_addr_a (in_a.ra),
    .retire_reg_data_a (in_a.rd),
    .retire_mem_addr_a (in_a.ma),
    .retire_mem_data_a (in_a.md),
    .retire_mem_wrt_a  (in_a.mw),
    .retire_valid_b    (in_b.valid),
    .retire_pc_b       (in_b.pc),
    .retire_inst_b     (in_b.inst),
    .retire_reg_addr_b (in_b.ra),
    .retire_reg_data_b (in_b.rd),
    .retire_mem_addr_b (in_b.ma),
    .retire_mem_data_b (in_b.md),
    .retire_mem_wrt_b  (in_b.mw),
    .trace_valid       (trace_valid),
    .trace_ready       (ready),
    .trace_lane        (trace_lane),
    .trace_seq         (trace_seq),
    .trace_pc          (trace_pc),
    .trace_inst        (trace_inst),
    .trace_reg_addr    (trace_reg_addr),
    .trace_reg_data    (trace_reg_data),
    .trace_mem_addr    (trace_mem_addr),
    .trace_mem_data    (trace_mem_data),
    .trace_mem_wrt     (trace_mem_wrt),
    .overflow          (overflow),
    .drop_count        (drop_count)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_candidate(input ret_t r);
`ifdef RETIRE_TRACE_FILTER_EN
    return r.valid && (r.ra != 5'd0 || r.mw);
`else
    return r.valid;
`endif
  endfunction

  function automatic rec_t to_rec(input ret_t r, input logic lane);
    rec_t x;
    x = '{lane: lane, seq: 32'd0, pc: r.pc, inst: r.inst, reg_addr: r.ra, reg_data: r.rd,
          mem_addr: r.ma, mem_data: r.md, mem_wrt: r.mw};
    return x;
  endfunction

  function automatic ret_t mk(input logic v, input logic [31:0] pc, input logic [4:0] ra,
                              input logic mw);
    ret_t r;
    r = '{valid: v, pc: pc, inst: pc ^ 32'h5a5a0000, ra: ra, rd: pc + 32'd7,
          ma: pc ^ 32'hffff, md: ~pc, mw: mw};
    return r;
  endfunction

  function automatic ret_t rand_ret(input int pct);
    ret_t r;
    r.valid = ($urandom_range(0, 99) < pct);
    r.pc    = $urandom;
    r.inst  = $urandom;
    r.ra    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    r.rd    = $urandom;
    r.ma    = $urandom;
    r.md    = $urandom;
    r.mw    = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_seq  = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    rec_t obs;
    obs = '{lane: trace_lane, seq: trace_seq, pc: trace_pc, inst: trace_inst,
            reg_addr: trace_reg_addr, reg_data: trace_reg_data, mem_addr: trace_mem_addr,
            mem_data: trace_mem_data, mem_wrt: trace_mem_wrt};
    check({tag, ".valid"}, 256'(trace_valid), 256'(mq.size() != 0));
    check({tag, ".head"}, 256'(obs), 256'(m_last));
    check({tag, ".overflow"}, 256'(overflow), 256'(m_ovf));
    check({tag, ".drop_count"}, 256'(drop_count), 256'(m_drop));
  endtask

  // Apply one cycle of stimulus, advance the model across the edge, then compare.
  task automatic step(input string tag, input ret_t a, input ret_t b, input logic rdy,
                      input logic clr);
    rec_t cands[$];
    rec_t acc[$];
    int   free;
    bit   do_pop;
    in_a  = a;
    in_b  = b;
    ready = rdy;
    clear = clr;
    @(posedge clk);
    if (clr) begin
      mq.delete();
      m_seq  = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
    end else begin
      free   = DEPTH - mq.size();
      do_pop = (mq.size() != 0) && rdy;
      if (is_candidate(a)) cands.push_back(to_rec(a, 1'b0));
      if (is_candidate(b)) cands.push_back(to_rec(b, 1'b1));
      foreach (cands[i]) begin
        if (free > 0) begin
          cands[i].seq = m_seq;
          m_seq = m_seq + 1;
          acc.push_back(cands[i]);
          free--;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 32'hffff_ffff) m_drop = m_drop + 1;
        end
      end
      if (do_pop) void'(mq.pop_front());
      foreach (acc[i]) mq.push_back(acc[i]);
    end
    if (mq.size() != 0) m_last = mq[0];
    #1;
    compare_all(tag);
  endtask

  ret_t idle;
  int   ready_pct;
  int   valid_pct;

  initial begin
    idle = '0;
    #2;
    check("reset.valid", 256'(trace_valid), 256'(0));
    check("reset.pc", 256'(trace_pc), 256'(0));
    check("reset.seq", 256'(trace_seq), 256'(0));
    check("reset.drop", 256'(drop_count), 256'(0));
    check("reset.ovf", 256'(overflow), 256'(0));
    #10 reset = 1'b1;

    // 1: single lane A
    step("t1", mk(1'b1, 32'h100, 5'd1, 1'b0), idle, 1'b0, 1'b0);
    check("t1.valid", 256'(trace_valid), 256'(1));
    check("t1.lane", 256'(trace_lane), 256'(0));
    check("t1.pc", 256'(trace_pc), 256'(32'h100));
    check("t1.seq", 256'(trace_seq), 256'(0));

    // 2: dual retirement, drained in program order
    step("t2.clr", idle, idle, 1'b0, 1'b1);
    step("t2.push", mk(1'b1, 32'h200, 5'd2, 1'b0), mk(1'b1, 32'h204, 5'd3, 1'b0), 1'b1, 1'b0);
    check("t2.pc0", 256'(trace_pc), 256'(32'h200));
    check("t2.seq0", 256'(trace_seq), 256'(0));
    step("t2.pop", idle, idle, 1'b1, 1'b0);
    check("t2.pc1", 256'(trace_pc), 256'(32'h204));
    check("t2.lane1", 256'(trace_lane), 256'(1));
    check("t2.seq1", 256'(trace_seq), 256'(1));

    // 3: fill to DEPTH, then overflow both lanes
    step("t3.clr", idle, idle, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step("t3.fill", mk(1'b1, 32'h1000 + 32'(i * 8), 5'd4, 1'b0),
           mk(1'b1, 32'h1004 + 32'(i * 8), 5'd5, 1'b1), 1'b0, 1'b0);
    end
    check("t3.ovf_before", 256'(overflow), 256'(0));
    step("t3.over", mk(1'b1, 32'h2000, 5'd6, 1'b0), mk(1'b1, 32'h2004, 5'd7, 1'b0), 1'b0, 1'b0);
    check("t3.ovf", 256'(overflow), 256'(1));
    check("t3.drop", 256'(drop_count), 256'(2));

    // 4: one free slot -> A kept, B dropped; a same-cycle pop does not add space
    step("t4.pop", idle, idle, 1'b1, 1'b0);
    step("t4.part", mk(1'b1, 32'h3000, 5'd8, 1'b0), mk(1'b1, 32'h3004, 5'd9, 1'b0), 1'b1, 1'b0);
    check("t4.drop", 256'(drop_count), 256'(3));
    for (int i = 0; i < 15; i++) step("t4.drain", idle, idle, 1'b1, 1'b0);
    check("t4.last_pc", 256'(trace_pc), 256'(32'h3000));
    check("t4.last_seq", 256'(trace_seq), 256'(16));

    // 5: clear beats push and pop
    step("t5.push", mk(1'b1, 32'h4000, 5'd1, 1'b0), idle, 1'b0, 1'b0);
    step("t5.clr", mk(1'b1, 32'h5000, 5'd1, 1'b0), mk(1'b1, 32'h5004, 5'd1, 1'b0), 1'b1, 1'b1);
    check("t5.valid", 256'(trace_valid), 256'(0));
    check("t5.drop", 256'(drop_count), 256'(0));
    check("t5.ovf", 256'(overflow), 256'(0));

    // 6: filter behaviour on a no-effect lane A
    step("t6.push", mk(1'b1, 32'h6000, 5'd0, 1'b0), mk(1'b1, 32'h6004, 5'd5, 1'b0), 1'b0, 1'b0);
    check("t6.seq", 256'(trace_seq), 256'(0));
`ifdef RETIRE_TRACE_FILTER_EN
    check("t6.lane", 256'(trace_lane), 256'(1));
    check("t6.pc", 256'(trace_pc), 256'(32'h6004));
`else
    check("t6.lane", 256'(trace_lane), 256'(0));
    check("t6.pc", 256'(trace_pc), 256'(32'h6000));
`endif

    // Random traffic with shifting ready/valid pressure
    ready_pct = 50;
    valid_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        ready_pct = $urandom_range(0, 100);
        valid_pct = $urandom_range(20, 100);
      end
      step("rand", rand_ret(valid_pct), rand_ret(valid_pct), ($urandom_range(0, 99) < ready_pct),
           ($urandom_range(0, 299) == 0));
      if (i == 1500) begin
        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #2 reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
